// File: rtl/updown_timer.sv
`default_nettype none
// ============================================================================
// Module      : updown_timer
// Description : BCD stopwatch / countdown timer with a prescaled count tick.
//               Digit 0 is least significant; with SEXAGESIMAL=1 digit 1
//               counts 0..5 so the low four digits read MM:SS.
// Ports       :
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous clear (level)
//   start_stop  in   pulse: start / pause / resume
//   mode_down   in   0 = count up, 1 = count down (latched at start)
//   set_time    in   pulse: load di into digit digit_sel (IDLE/PAUSED only)
//   digit_sel   in   [2:0] digit to load, out-of-range values ignored
//   di          in   [3:0] BCD value to load, clamped to the digit maximum
//   digits      out  [4*NUM_DIGITS-1:0] current count
//   running     out  high in RUN
//   done        out  high in DONE
//   tick        out  one-cycle pulse for every applied count step
// Revision    : 1.0 - initial release
// ============================================================================
module updown_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 1000000,
  parameter int SEXAGESIMAL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    start_stop,
  input  logic                    mode_down,
  input  logic                    set_time,
  input  logic [2:0]              digit_sel,
  input  logic [3:0]              di,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    done,
  output logic                    tick
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int PSC_W = $clog2(TICK_DIV);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic logic [3:0] digit_max(input int k);
    return (SEXAGESIMAL != 0 && k == 1) ? 4'd5 : 4'd9;
  endfunction

  logic             r_en;      // goes high one edge after reset release
  logic [1:0]       r_state;
  logic [DW-1:0]    r_digits;
  logic [PSC_W-1:0] r_psc;
  logic             r_dir;
  logic             r_tick;

  logic [DW-1:0]    w_inc;
  logic [DW-1:0]    w_dec;
  logic [DW-1:0]    w_max_val;
  logic [DW-1:0]    w_load_val;
  logic [DW-1:0]    w_count_next;
  logic             w_all_max;
  logic             w_zero;
  logic             w_load_ok;
  logic             w_psc_last;
  logic             w_terminal;

  // Ripple BCD increment/decrement plus the clamped load value.
  always_comb begin
    logic       c;
    logic       b;
    logic [3:0] d;
    logic [3:0] mx;
    c          = 1'b1;
    b          = 1'b1;
    d          = 4'd0;
    mx         = 4'd0;
    w_inc      = '0;
    w_dec      = '0;
    w_max_val  = '0;
    w_load_val = r_digits;
    w_all_max  = 1'b1;
    w_zero     = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d  = r_digits[4*k +: 4];
      mx = digit_max(k);
      w_max_val[4*k +: 4] = mx;
      if (d != mx) w_all_max = 1'b0;
      if (d != 4'd0) w_zero = 1'b0;
      if (c) begin
        if (d >= mx) begin
          w_inc[4*k +: 4] = 4'd0;
        end else begin
          w_inc[4*k +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end else begin
        w_inc[4*k +: 4] = d;
      end
      if (b) begin
        if (d == 4'd0) begin
          w_dec[4*k +: 4] = mx;
        end else begin
          w_dec[4*k +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end else begin
        w_dec[4*k +: 4] = d;
      end
      if (int'(digit_sel) == k) w_load_val[4*k +: 4] = (di > mx) ? mx : di;
    end
  end

  assign w_load_ok  = (int'(digit_sel) < NUM_DIGITS);
  assign w_psc_last = (r_psc == PSC_W'(TICK_DIV - 1));

  // Both directions saturate at their terminal value instead of wrapping.
  assign w_count_next = r_dir ? (w_zero ? '0 : w_dec)
                              : (w_all_max ? r_digits : w_inc);
  assign w_terminal   = r_dir ? (w_count_next == '0)
                              : (w_count_next == w_max_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_state  <= S_IDLE;
      r_digits <= '0;
      r_psc    <= '0;
      r_dir    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_en   <= 1'b1;
      r_tick <= 1'b0;
      if (r_en) begin
        if (clr) begin
          r_state  <= S_IDLE;
          r_digits <= '0;
          r_psc    <= '0;
          r_dir    <= 1'b0;
        end else begin
          case (r_state)
            S_IDLE: begin
              // A countdown from zero would finish instantly; refuse it.
              if (start_stop && !(mode_down && w_zero)) begin
                r_state <= S_RUN;
                r_dir   <= mode_down;
                r_psc   <= '0;
              end else if (set_time && w_load_ok) begin
                r_digits <= w_load_val;
                r_psc    <= '0;
              end
            end
            S_RUN: begin
              if (w_psc_last) begin
                r_psc    <= '0;
                r_tick   <= 1'b1;
                r_digits <= w_count_next;
                if (w_terminal)      r_state <= S_DONE;
                else if (start_stop) r_state <= S_PAUSED;
              end else begin
                r_psc <= r_psc + PSC_W'(1);
                if (start_stop) r_state <= S_PAUSED;
              end
            end
            S_PAUSED: begin
              if (start_stop) begin
                r_state <= S_RUN;
              end else if (set_time && w_load_ok) begin
                r_digits <= w_load_val;
                r_psc    <= '0;
              end
            end
            default: begin
              // DONE: only clr or reset leaves this state.
            end
          endcase
        end
      end
    end
  end

  assign digits  = r_digits;
  assign running = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_updown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_timer
// Description : Self-checking bench for updown_timer (4 digits, TICK_DIV=4,
//               MM:SS). Expected count values come from an integer
//               seconds-to-MM:SS model and are queued before each run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_timer;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        start_stop;
  logic        mode_down;
  logic        set_time;
  logic [2:0]  digit_sel;
  logic [3:0]  di;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        tick;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  updown_timer #(.NUM_DIGITS(4), .TICK_DIV(4), .SEXAGESIMAL(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .start_stop (start_stop),
    .mode_down  (mode_down),
    .set_time   (set_time),
    .digit_sel  (digit_sel),
    .di         (di),
    .digits     (digits),
    .running    (running),
    .done       (done),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Seconds -> MM:SS in BCD.
  function automatic logic [15:0] mmss(input int t);
    int m;
    int s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic load(input logic [2:0] sel, input logic [3:0] val);
    digit_sel = sel;
    di        = val;
    set_time  = 1'b1;
    step();
    set_time  = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < limit) begin
      step();
      n++;
      if (tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL reset_digits: got %h want 0000", digits); end
    total++; if ({running, done, tick} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {running, done, tick}); end
    // Release, then a start pulse on the very first edge must be ignored.
    rst_n = 1'b1;
    mode_down = 1'b0;
    pulse_start();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_first_edge: running got %b want 0", running); end
    pulse_start();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL reset_second_edge: running got %b want 1", running); end
    pulse_clr();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL clr_idle: running got %b want 0", running); end
  endtask

  task automatic test_count_up();
    bit ok;
    int n;
    logic [15:0] e;
    pulse_clr();
    mode_down = 1'b0;
    pulse_start();
    for (int t = 1; t <= 60; t++) exp_q.push_back(mmss(t));
    for (int t = 1; t <= 60; t++) begin
      wait_tick(10, ok, n);
      e = exp_q.pop_front();
      total++; if (!ok || n != 4) begin bad++; $display("FAIL up_spacing[%0d]: got %0d cycles ok=%0d want 4", t, n, ok); end
      total++; if (digits !== e) begin bad++; $display("FAIL up_digits[%0d]: got %h want %h", t, digits, e); end
    end
    total++; if (digits !== 16'h0100 || running !== 1'b1) begin bad++; $display("FAIL up_60: got %h run=%b want 0100 run=1", digits, running); end
    pulse_clr();
  endtask

  task automatic test_count_down();
    bit ok;
    int n;
    logic [15:0] e;
    pulse_clr();
    mode_down = 1'b1;
    pulse_start();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL down_from_zero: running got %b want 0", running); end
    load(3'd0, 4'd3);
    total++; if (digits !== 16'h0003) begin bad++; $display("FAIL down_load: got %h want 0003", digits); end
    pulse_start();
    mode_down = 1'b0;  // latched direction must stay down
    for (int t = 2; t >= 0; t--) exp_q.push_back(mmss(t));
    for (int i = 0; i < 3; i++) begin
      wait_tick(10, ok, n);
      e = exp_q.pop_front();
      total++; if (!ok || n != 4) begin bad++; $display("FAIL down_spacing[%0d]: got %0d cycles ok=%0d want 4", i, n, ok); end
      total++; if (digits !== e) begin bad++; $display("FAIL down_digits[%0d]: got %h want %h", i, digits, e); end
    end
    total++; if (done !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL down_done: done=%b run=%b want 1 0", done, running); end
    pulse_clr();
  endtask

  task automatic test_pause();
    bit ok;
    int n;
    bit seen;
    pulse_clr();
    mode_down = 1'b0;
    pulse_start();
    for (int i = 0; i < 2; i++) wait_tick(10, ok, n);
    total++; if (digits !== 16'h0002) begin bad++; $display("FAIL pause_pre: got %h want 0002", digits); end
    step();           // prescaler now 1
    pulse_start();    // pausing edge still advances prescaler to 2
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick === 1'b1 || digits !== 16'h0002 || running !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL pause_hold: got %h run=%b want 0002 run=0 no tick", digits, running); end
    pulse_start();
    exp_q.push_back(mmss(3));
    wait_tick(10, ok, n);
    total++; if (!ok || n != 2) begin bad++; $display("FAIL pause_resume_spacing: got %0d ok=%0d want 2", n, ok); end
    total++; if (digits !== exp_q[0]) begin bad++; $display("FAIL pause_resume_digits: got %h want %h", digits, exp_q[0]); end
    void'(exp_q.pop_front());
    pulse_clr();
  endtask

  task automatic test_saturate();
    bit ok;
    int n;
    pulse_clr();
    load(3'd3, 4'd9);
    load(3'd2, 4'd9);
    load(3'd1, 4'd5);
    load(3'd0, 4'd8);
    total++; if (digits !== 16'h9958) begin bad++; $display("FAIL sat_load: got %h want 9958", digits); end
    mode_down = 1'b0;
    pulse_start();
    exp_q.push_back(16'h9959);
    wait_tick(10, ok, n);
    total++; if (!ok || digits !== exp_q[0]) begin bad++; $display("FAIL sat_digits: got %h ok=%0d want %h", digits, ok, exp_q[0]); end
    void'(exp_q.pop_front());
    total++; if (done !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL sat_done: done=%b run=%b want 1 0", done, running); end
    pulse_start();
    repeat (6) step();
    total++; if (digits !== 16'h9959 || done !== 1'b1) begin bad++; $display("FAIL sat_hold: got %h done=%b want 9959 1", digits, done); end
    pulse_clr();
    total++; if (digits !== 16'h0000 || done !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL sat_clr: got %h done=%b run=%b want 0000 0 0", digits, done, running); end
  endtask

  task automatic test_set_time();
    pulse_clr();
    load(3'd1, 4'd9);
    total++; if (digits !== 16'h0050) begin bad++; $display("FAIL set_clamp: got %h want 0050", digits); end
    load(3'd5, 4'd7);
    total++; if (digits !== 16'h0050) begin bad++; $display("FAIL set_bad_sel: got %h want 0050", digits); end
    load(3'd3, 4'd4);
    total++; if (digits !== 16'h4050) begin bad++; $display("FAIL set_digit3: got %h want 4050", digits); end
    mode_down = 1'b0;
    pulse_start();
    load(3'd0, 4'd7);
    total++; if (digits !== 16'h4050) begin bad++; $display("FAIL set_in_run: got %h want 4050", digits); end
    pulse_clr();
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    pulse_clr();
    mode_down = 1'b0;
    pulse_start();
    wait_tick(10, ok, n);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (digits !== 16'h0000 || running !== 1'b0) begin bad++; $display("FAIL async_reset: got %h run=%b want 0000 0", digits, running); end
    step();
    rst_n = 1'b1;
    wait_tick(12, ok, n);
    total++; if (ok || running !== 1'b0) begin bad++; $display("FAIL reset_no_resume: tick=%0d run=%b want 0 0", ok, running); end
  endtask

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b0;
    start_stop = 1'b0;
    mode_down  = 1'b0;
    set_time   = 1'b0;
    digit_sel  = 3'd0;
    di         = 4'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_pause();
    test_saturate();
    test_set_time();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updown_timer.md
UPDOWN_TIMER -- requirements
Module: updown_timer

Interface
REQ-001 Parameter NUM_DIGITS, default 4, is the number of BCD digits, legal range 2..8; digit 0 is least significant.
REQ-002 Parameter TICK_DIV, default 1000000, is the number of clk cycles per count tick, legal range >=2.
REQ-003 Parameter SEXAGESIMAL, default 1; when 1, digit 1 counts 0..5 (MM:SS format); when 0, every digit counts 0..9.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 clr  input  1  synchronous clear, active-high, level.
REQ-007 start_stop  input  1  single-cycle pulse that starts, pauses or resumes counting.
REQ-008 mode_down  input  1  0 = stopwatch (count up), 1 = timer (count down).
REQ-009 set_time  input  1  single-cycle pulse that loads di into the digit selected by digit_sel.
REQ-010 digit_sel  input  3  index of the digit to load; values >= NUM_DIGITS are ignored.
REQ-011 di  input  4  BCD value to load.
REQ-012 digits  output  4*NUM_DIGITS  current count; digit k occupies bits [4k+3:4k].
REQ-013 running  output  1  high while in RUN.
REQ-014 done  output  1  high while in DONE.
REQ-015 tick  output  1  one-cycle pulse on each count tick applied.

Function
REQ-016 FSM states: IDLE, RUN, PAUSED, DONE; the encoding is internal.
REQ-017 Priority order each cycle: clr, then start_stop/tick, then set_time.
REQ-018 clr in any state: next state IDLE, digits=0, prescaler=0, latched direction=0.
REQ-019 start_stop transitions: IDLE->RUN; RUN->PAUSED; PAUSED->RUN; DONE ignored (clr required).
REQ-020 IDLE->RUN when mode_down=1 and digits==0: start_stop is ignored and the FSM stays IDLE.
REQ-021 mode_down is latched on the IDLE->RUN transition; changes during RUN or PAUSED have no effect.
REQ-022 Prescaler: counts 0..TICK_DIV-1 only in RUN, holds its value in PAUSED, and is cleared on clr and on every set_time load.
REQ-023 Prescaler reaching TICK_DIV-1 in RUN: prescaler wraps to 0, tick=1 for that cycle, count updates by one.
REQ-024 Up count: BCD increment with per-digit carry; digit 1 wraps 5->0 when SEXAGESIMAL=1.
REQ-025 Up count reaching all-max (e.g. 99:59): value saturates, and the FSM enters DONE on the same edge.
REQ-026 Down count: BCD decrement with per-digit borrow; digit 1 borrows to 5 when SEXAGESIMAL=1.
REQ-027 Down count reaching 0: the FSM enters DONE on the same edge, and digits hold 0.
REQ-028 Tick and start_stop in the same RUN cycle: the tick is applied, then the FSM goes to PAUSED; if the tick reaches terminal, DONE wins.
REQ-029 set_time is accepted only in IDLE and PAUSED, and is ignored in RUN and DONE.
REQ-030 A loaded value greater than the digit's maximum (9, or 5 for SEXAGESIMAL digit 1) is clamped to that maximum.
REQ-031 The loaded digit is visible on digits the cycle after the set_time pulse; other digits are unchanged.
REQ-032 Outputs are registered: running, done and tick reflect state after the clock edge, with no combinational input-to-output path.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, digits=0, prescaler=0, latched direction=0, running=0, done=0, tick=0.
REQ-034 Reset deassertion mid-RUN restarts from IDLE; no count resumes without a new start_stop.
REQ-035 Release of rst_n is used synchronously; the first state change occurs on the second rising clk edge after release.

Verification (NUM_DIGITS=4, TICK_DIV=4, SEXAGESIMAL=1)
REQ-036 Scenario: reset, start_stop with mode_down=0 -> tick every 4 cycles; after 60 ticks digits=01:00; running=1.
REQ-037 Scenario: load 00:03 via set_time (digit0=3), mode_down=1, start_stop -> digits 02, 01, 00 at 4-cycle spacing; done=1, running=0 on the edge that reaches 00:00.
REQ-038 Scenario: start up count, start_stop after 2 ticks -> PAUSED, digits=00:02 held for 20 cycles; start_stop -> the next tick arrives after the remaining prescaler cycles (no lost count).
REQ-039 Scenario: preload 99:58, count up 1 tick -> 99:59 and DONE; further start_stop -> no change; clr -> 00:00, IDLE.
REQ-040 Scenario: set_time digit_sel=1, di=9 -> digit1=5 (clamp); set_time during RUN -> ignored; digit_sel=5 -> ignored.
REQ-041 Scenario: assert rst_n low mid-RUN between clock edges -> digits=0, running=0 immediately, without waiting for a clk edge.
